// File: rtl/tx_framer.sv
// ISO/IEC 14443A Type A PICC transmit framer.
// Frames sender bytes as SOC, LSb-first data, optional odd parity and optional
// CRC_A, then EOC. Each bit is Manchester-encoded and gated with the subcarrier
// to drive the load modulator.
module tx_framer #(
  parameter int unsigned BIT_TICKS = 128,
  parameter int unsigned SC_HALF   = 8,
  parameter logic [15:0] CRC_INIT  = 16'h6363
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fdt_trigger,
  input  logic [7:0] data,
  input  logic [2:0] data_bits,
  input  logic       ready_to_send,
  input  logic       parity_en,
  input  logic       append_crc,
  output logic       req,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int unsigned TW = $clog2(BIT_TICKS);
  localparam int unsigned SW = $clog2(2 * SC_HALF);

  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(BIT_TICKS / 2);
  localparam logic [SW-1:0] SC_LAST   = SW'(2 * SC_HALF - 1);
  localparam logic [SW-1:0] SC_ON     = SW'(SC_HALF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOC,
    S_DATA,
    S_PARITY,
    S_EOC
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   sc_q, sc_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      bits_left_q, bits_left_d;
  logic            par_q, par_d;
  logic            par_en_q, par_en_d;
  logic            crc_en_q, crc_en_d;
  logic [15:0]     crc_q, crc_d;
  logic [7:0]      crc_hi_q, crc_hi_d;
  logic            crc_phase_q, crc_phase_d;
  logic [1:0]      crc_cnt_q, crc_cnt_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic            cur_bit, next_bit, bit_end, load_next;
  logic [15:0]     crc_upd;

  // Level on the line for a given state: SOC is a 1, DATA is the shift LSb,
  // PARITY is the running odd-parity accumulator.
  function automatic logic line_bit(input state_t s, input logic [7:0] sh, input logic p);
    case (s)
      S_SOC:    return 1'b1;
      S_DATA:   return sh[0];
      S_PARITY: return p;
      default:  return 1'b0;
    endcase
  endfunction

  // A data_bits value of 0 stands for a full byte.
  function automatic logic [3:0] byte_len(input logic [2:0] nb);
    return (nb == 3'd0) ? 4'd8 : {1'b0, nb};
  endfunction

  // Frame sequencing, bit timing, CRC/parity accumulation and registered tx level.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    par_d       = par_q;
    par_en_d    = par_en_q;
    crc_en_d    = crc_en_q;
    crc_d       = crc_q;
    crc_hi_d    = crc_hi_q;
    crc_phase_d = crc_phase_q;
    crc_cnt_d   = crc_cnt_q;
    load_next   = 1'b0;

    bit_end = (tick_q == TICK_LAST);
    cur_bit = line_bit(state_q, shreg_q, par_q);
    crc_upd = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ cur_bit) ? 16'h8408 : 16'h0000);

    case (state_q)
      S_IDLE: begin
        if (fdt_trigger && ready_to_send) begin
          state_d     = S_SOC;
          shreg_d     = data;
          bits_left_d = byte_len(data_bits);
          par_en_d    = parity_en;
          crc_en_d    = append_crc;
          crc_d       = CRC_INIT;
          par_d       = 1'b1;
          crc_phase_d = 1'b0;
          crc_cnt_d   = 2'd0;
        end
      end
      S_SOC: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d     = {1'b0, shreg_q[7:1]};
          par_d       = par_q ^ cur_bit;
          bits_left_d = bits_left_q - 1'b1;
          // The CRC covers only sender bits, never the CRC bytes themselves.
          if (!crc_phase_q) crc_d = crc_upd;
          if (bits_left_q == 4'd1) begin
            if (par_en_q) state_d = S_PARITY;
            else          load_next = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) load_next = 1'b1;
      end
      S_EOC: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // End of a byte: next sender byte, then the CRC bytes, then EOC.
    if (load_next) begin
      if (!crc_phase_q && ready_to_send) begin
        shreg_d     = data;
        bits_left_d = byte_len(data_bits);
        par_d       = 1'b1;
        state_d     = S_DATA;
      end else if (crc_en_q && crc_cnt_q != 2'd2) begin
        crc_phase_d = 1'b1;
        bits_left_d = 4'd8;
        par_d       = 1'b1;
        crc_cnt_d   = crc_cnt_q + 1'b1;
        state_d     = S_DATA;
        if (crc_cnt_q == 2'd0) begin
          // crc_d already includes the final sender bit at this point.
          shreg_d  = crc_d[7:0];
          crc_hi_d = crc_d[15:8];
        end else begin
          shreg_d  = crc_hi_q;
        end
      end else begin
        state_d = S_EOC;
      end
    end

    // Bit-tick and subcarrier counters restart together at SOC tick 0.
    if (state_q == S_IDLE || state_d == S_IDLE || bit_end) tick_d = '0;
    else                                                   tick_d = tick_q + 1'b1;
    if (state_q == S_IDLE || state_d == S_IDLE || sc_q == SC_LAST) sc_d = '0;
    else                                                           sc_d = sc_q + 1'b1;

    // tx is computed from next-state values so the registered output lines up
    // with tick_q on the following cycle.
    next_bit = line_bit(state_d, shreg_d, par_d);
    tx_d     = (state_d == S_SOC || state_d == S_DATA || state_d == S_PARITY) &&
               (sc_d < SC_ON) &&
               ((tick_d < TICK_HALF) ? next_bit : ~next_bit);

    done_d = (state_q == S_EOC) && bit_end;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      sc_q        <= '0;
      shreg_q     <= '0;
      bits_left_q <= '0;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
      crc_en_q    <= 1'b0;
      crc_q       <= '0;
      crc_hi_q    <= '0;
      crc_phase_q <= 1'b0;
      crc_cnt_q   <= '0;
      tx_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      sc_q        <= sc_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      par_q       <= par_d;
      par_en_q    <= par_en_d;
      crc_en_q    <= crc_en_d;
      crc_q       <= crc_d;
      crc_hi_q    <= crc_hi_d;
      crc_phase_q <= crc_phase_d;
      crc_cnt_q   <= crc_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  // req marks tick 0 of the last bit of each sender byte (parity bit if enabled).
  always_comb begin
    req = (tick_q == '0) && !crc_phase_q &&
          (par_en_q ? (state_q == S_PARITY)
                    : (state_q == S_DATA && bits_left_q == 4'd1));
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: default timing instance plus a 64/4 instance.
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig0 = 1'b0, trig1 = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] nbits = 3'd0;
  logic       rts = 1'b0, par_en = 1'b0, crc_en = 1'b0;
  logic       req0, busy0, done0, tx0;
  logic       req1, busy1, done1, tx1;
  logic       sel = 1'b0;
  logic       req_s, busy_s, done_s, tx_s;

  int checks = 0;
  int errors = 0;

  // Capture of the most recent frame.
  int    busy_cnt, req_cnt, done_cnt, done_at, last_tx_hi, man_bad;
  int    req_at [4];
  logic  t0 [64];
  logic  th [64];
  logic  soc_wave [128];
  string obs;

  always #5 clk = ~clk;

  assign req_s  = sel ? req1  : req0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign tx_s   = sel ? tx1   : tx0;

  tx_framer u_dut (
    .clk(clk), .rst_n(rst_n), .fdt_trigger(trig0), .data(data), .data_bits(nbits),
    .ready_to_send(rts), .parity_en(par_en), .append_crc(crc_en),
    .req(req0), .busy(busy0), .done(done0), .tx(tx0)
  );

  tx_framer #(.BIT_TICKS(64), .SC_HALF(4)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .fdt_trigger(trig1), .data(data), .data_bits(nbits),
    .ready_to_send(rts), .parity_en(par_en), .append_crc(crc_en),
    .req(req1), .busy(busy1), .done(done1), .tx(tx1)
  );

  // Start a frame on the selected instance, act as the sender on req, and
  // record busy length, req/done timing and tx at tick 0 and mid-bit.
  task automatic run_frame(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [2:0] n0, input logic [2:0] n1,
                           input logic pe, input logic ce, input int trig_at);
    int bt, half, sent, nper;
    bt = sel ? 64 : 128;
    half = bt / 2;
    busy_cnt = 0; req_cnt = 0; done_cnt = 0; done_at = -1; last_tx_hi = -1; man_bad = 0;
    for (int i = 0; i < 4; i++) req_at[i] = -1;
    for (int i = 0; i < 64; i++) begin t0[i] = 1'b0; th[i] = 1'b0; end
    for (int i = 0; i < 128; i++) soc_wave[i] = 1'b0;
    @(negedge clk);
    data = b0; nbits = n0; rts = 1'b1; par_en = pe; crc_en = ce;
    trig0 = ~sel; trig1 = sel;
    @(negedge clk);
    trig0 = 1'b0; trig1 = 1'b0;
    sent = 1;
    for (int k = 0; k < 64 * bt + 16; k++) begin
      if (busy_s) busy_cnt++;
      if (tx_s) last_tx_hi = k;
      if (k < 64 * bt && (k % bt) == 0)    t0[k / bt] = tx_s;
      if (k < 64 * bt && (k % bt) == half) th[k / bt] = tx_s;
      if (k < bt) soc_wave[k] = tx_s;
      if (req_s) begin
        if (req_cnt < 4) req_at[req_cnt] = k;
        req_cnt++;
        if (sent < nbytes) begin data = b1; nbits = n1; sent++; end
        else rts = 1'b0;
      end
      if (done_s) begin done_cnt++; done_at = k; end
      trig0 = (k == trig_at) && !sel;
      trig1 = (k == trig_at) && sel;
      if (done_cnt != 0 && k >= done_at + 8) break;
      @(negedge clk);
    end
    trig0 = 1'b0; trig1 = 1'b0; rts = 1'b0;
    nper = busy_cnt / bt;
    if (nper > 64) nper = 64;
    obs = "";
    for (int i = 0; i < nper - 1; i++) begin
      if (t0[i]) obs = {obs, "1"};
      else       obs = {obs, "0"};
      if (th[i] !== ~t0[i]) man_bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, req0, done0, tx0} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {busy0, req0, done0, tx0});
    end
    checks++;
    if ({busy1, req1, done1, tx1} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs_fast got %b want 0000", {busy1, req1, done1, tx1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy0); end
  endtask

  task automatic test_single_parity();
    sel = 1'b0;
    run_frame(1, 8'hA5, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, -1);
    checks++; if (busy_cnt !== 1408) begin errors++; $display("FAIL a5_busy got %0d want 1408", busy_cnt); end
    checks++; if (obs != "1101001011") begin errors++; $display("FAIL a5_bits got %s want 1101001011", obs); end
    checks++; if (req_cnt !== 1) begin errors++; $display("FAIL a5_req_count got %0d want 1", req_cnt); end
    checks++; if (req_at[0] !== 1152) begin errors++; $display("FAIL a5_req_tick got %0d want 1152", req_at[0]); end
    checks++; if (done_cnt !== 1 || done_at !== 1408) begin
      errors++; $display("FAIL a5_done got count %0d at %0d want 1 at 1408", done_cnt, done_at);
    end
    checks++; if (man_bad !== 0) begin errors++; $display("FAIL a5_manchester got %0d bad want 0", man_bad); end
    checks++; if (last_tx_hi !== 1207) begin errors++; $display("FAIL a5_last_tx_high got %0d want 1207", last_tx_hi); end
  endtask

  task automatic test_crc_parity();
    sel = 1'b0;
    run_frame(2, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1, -1);
    checks++; if (busy_cnt !== 38 * 128) begin errors++; $display("FAIL crc00_busy got %0d want %0d", busy_cnt, 38 * 128); end
    checks++;
    if (obs != "1000000001000000001000001011011110001") begin
      errors++; $display("FAIL crc00_bits got %s want 1000000001000000001000001011011110001", obs);
    end
    checks++; if (req_cnt !== 2 || req_at[0] !== 1152 || req_at[1] !== 2304) begin
      errors++; $display("FAIL crc00_req got %0d at %0d,%0d want 2 at 1152,2304", req_cnt, req_at[0], req_at[1]);
    end
    checks++; if (done_cnt !== 1 || done_at !== 38 * 128) begin
      errors++; $display("FAIL crc00_done got count %0d at %0d want 1 at 4864", done_cnt, done_at);
    end
    checks++; if (man_bad !== 0) begin errors++; $display("FAIL crc00_manchester got %0d bad want 0", man_bad); end
  endtask

  task automatic test_crc_noparity(input string tag);
    sel = 1'b0;
    run_frame(2, 8'h12, 8'h34, 3'd0, 3'd0, 1'b0, 1'b1, -1);
    checks++; if (busy_cnt !== 34 * 128) begin errors++; $display("FAIL %s_busy got %0d want %0d", tag, busy_cnt, 34 * 128); end
    checks++;
    if (obs != "101001000001011000110010011110011") begin
      errors++; $display("FAIL %s_bits got %s want 101001000001011000110010011110011", tag, obs);
    end
    checks++; if (req_cnt !== 2 || req_at[0] !== 1024 || req_at[1] !== 2048) begin
      errors++; $display("FAIL %s_req got %0d at %0d,%0d want 2 at 1024,2048", tag, req_cnt, req_at[0], req_at[1]);
    end
    checks++; if (done_cnt !== 1 || done_at !== 34 * 128) begin
      errors++; $display("FAIL %s_done got count %0d at %0d want 1 at 4352", tag, done_cnt, done_at);
    end
    checks++; if (last_tx_hi >= 33 * 128 || last_tx_hi < 0) begin
      errors++; $display("FAIL %s_eoc_quiet got last tx high %0d want in 0..4223", tag, last_tx_hi);
    end
  endtask

  task automatic test_short_frame();
    int  wave_bad;
    logic e;
    sel = 1'b0;
    run_frame(1, 8'h26, 8'h00, 3'd7, 3'd0, 1'b0, 1'b0, -1);
    checks++; if (busy_cnt !== 9 * 128) begin errors++; $display("FAIL short_busy got %0d want 1152", busy_cnt); end
    checks++; if (obs != "10110010") begin errors++; $display("FAIL short_bits got %s want 10110010", obs); end
    checks++; if (req_cnt !== 1 || req_at[0] !== 896) begin
      errors++; $display("FAIL short_req got %0d at %0d want 1 at 896", req_cnt, req_at[0]);
    end
    wave_bad = 0;
    for (int t = 0; t < 128; t++) begin
      e = (t < 64) && ((t % 16) < 8);
      if (soc_wave[t] !== e) wave_bad++;
    end
    checks++; if (wave_bad !== 0) begin errors++; $display("FAIL short_soc_wave got %0d bad ticks want 0", wave_bad); end
  endtask

  task automatic test_ignored_trigger();
    int seen;
    sel = 1'b0;
    @(negedge clk);
    rts = 1'b0; data = 8'hFF; trig0 = 1'b1;
    @(negedge clk);
    trig0 = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy0 || req0 || done0 || tx0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL trig_no_rts got %0d active cycles want 0", seen); end
    run_frame(1, 8'hA5, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 500);
    checks++; if (busy_cnt !== 1408) begin errors++; $display("FAIL trig_busy_len got %0d want 1408", busy_cnt); end
    checks++; if (req_cnt !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL trig_busy_pulses got req %0d done %0d want 1 1", req_cnt, done_cnt);
    end
    checks++; if (obs != "1101001011") begin errors++; $display("FAIL trig_busy_bits got %s want 1101001011", obs); end
  endtask

  task automatic test_scaled();
    int  wave_bad;
    logic e;
    sel = 1'b1;
    run_frame(1, 8'hA5, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, -1);
    checks++; if (busy_cnt !== 704) begin errors++; $display("FAIL fast_busy got %0d want 704", busy_cnt); end
    checks++; if (obs != "1101001011") begin errors++; $display("FAIL fast_bits got %s want 1101001011", obs); end
    checks++; if (req_cnt !== 1 || req_at[0] !== 576) begin
      errors++; $display("FAIL fast_req got %0d at %0d want 1 at 576", req_cnt, req_at[0]);
    end
    checks++; if (done_cnt !== 1 || done_at !== 704) begin
      errors++; $display("FAIL fast_done got count %0d at %0d want 1 at 704", done_cnt, done_at);
    end
    checks++; if (last_tx_hi !== 603) begin errors++; $display("FAIL fast_last_tx_high got %0d want 603", last_tx_hi); end
    wave_bad = 0;
    for (int t = 0; t < 64; t++) begin
      e = (t < 32) && ((t % 8) < 4);
      if (soc_wave[t] !== e) wave_bad++;
    end
    checks++; if (wave_bad !== 0) begin errors++; $display("FAIL fast_soc_wave got %0d bad ticks want 0", wave_bad); end
    sel = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen;
    sel = 1'b0;
    @(negedge clk);
    data = 8'h12; nbits = 3'd0; rts = 1'b1; par_en = 1'b0; crc_en = 1'b1; trig0 = 1'b1;
    @(negedge clk);
    trig0 = 1'b0;
    // Tick 64 of the third data bit (a 0): tx is high in the second half.
    repeat (448) @(negedge clk);
    checks++; if (busy0 !== 1'b1 || tx0 !== 1'b1) begin
      errors++; $display("FAIL abort_pre got busy %b tx %b want 1 1", busy0, tx0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({busy0, req0, done0, tx0} !== 4'b0000) begin
      errors++; $display("FAIL abort_outputs got %b want 0000", {busy0, req0, done0, tx0});
    end
    rst_n = 1'b1; rts = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy0 || done0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
    test_crc_noparity("after_abort");
  endtask

  initial begin
    test_reset();
    test_single_parity();
    test_crc_parity();
    test_crc_noparity("crc1234");
    test_short_frame();
    test_ignored_trigger();
    test_scaled();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_framer.md
Name: tx_framer

Overview:
- Parametrised next-generation PICC transmitter.
- Serialises sender-supplied bytes into an ISO/IEC 14443A Type A frame: SOC, data LSb first, optional odd parity, optional hardware-appended CRC_A, then EOC.
- Manchester-encodes each bit and ANDs it with an internally generated subcarrier to drive the load modulator.
- Sits between the frame-delay timer / framing logic and the analogue modulator output; contains its own subcarrier and bit-encoder logic, with no submodules.

Parameters:
- BIT_TICKS, 128, clk ticks per bit period. Must be even and >=8.
- SC_HALF, 8, ticks per subcarrier half-period. Must divide BIT_TICKS/2.
- CRC_INIT, 16'h6363, CRC_A preset value.

Ports:
- clk  in  1  13.56 MHz clock.
- rst_n  in  1  synchronous, active-low reset.
- fdt_trigger  in  1  one-tick pulse; starts a frame if idle and ready_to_send=1.
- data  in  8  byte to send.
- data_bits  in  3  valid bits in data; 0 means 8.
- ready_to_send  in  1  data/data_bits valid.
- parity_en  in  1  append odd parity after every byte; sampled on start.
- append_crc  in  1  append 2-byte CRC_A after the last sender byte; sampled on start.
- req  out  1  one-tick pulse requesting the next byte.
- busy  out  1  high from the tick after start until return to IDLE.
- done  out  1  one-tick pulse on entry to IDLE at end of frame.
- tx  out  1  subcarrier AND Manchester-encoded bit.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; req=0, busy=0, done=0, tx=0; bit-tick and subcarrier counters cleared. Reset mid-frame aborts the frame immediately with no done pulse.
- Start condition: IDLE & fdt_trigger & ready_to_send.
  - Cache data, data_bits, parity_en, append_crc.
  - Load CRC with CRC_INIT.
  - Next state is SOC; busy rises next edge.
- fdt_trigger is ignored outside IDLE or when ready_to_send=0.
- Bit timing:
  - The tick counter runs 0..BIT_TICKS-1 whenever not IDLE.
  - Bit transitions and state changes occur only on tick BIT_TICKS-1.
  - Encoded level = bit for ticks < BIT_TICKS/2, else ~bit.
- Subcarrier:
  - Counter is cleared in IDLE.
  - Output is 1 for ticks 0..SC_HALF-1, then 0 for SC_HALF ticks, repeating, aligned to bit tick 0.
  - tx = subcarrier & encoded; tx is registered 0 in IDLE and EOC.
- States:
  - SOC: sends bit 1 → DATA.
  - DATA: sends cached[0], shifts right each bit.
    - CRC updates per bit: crc = (crc>>1) ^ (0x8408 if crc[0]^bit).
    - Parity accumulator, preset to 1, XORs each bit.
    - After the last bit (data_bits, 0 meaning 8): go to PARITY if parity_en, else to the next-byte decision.
  - PARITY: sends the accumulator (odd parity).
  - Next-byte decision, evaluated on the final tick of the byte's last bit:
    - ready_to_send=1 (sender phase only): load data/data_bits → DATA.
    - Else if append_crc and CRC not yet sent: load crc[7:0], then crc[15:8] (high byte snapshotted at the low-byte load); 8 bits each → DATA (CRC byte phase).
    - Else → EOC.
  - EOC: one bit period with tx=0 → IDLE; done=1 for that one edge.
- req:
  - Pulses one tick on tick 0 of the last bit of each sender byte: the parity bit if parity_en, else the last data bit.
  - Never pulses during CRC bytes.
  - The sender must present the next byte, or drop ready_to_send, before tick BIT_TICKS-1 of that bit.
- ready_to_send is ignored during CRC phase.
- Partial bytes (data_bits≠0) are allowed in any position; CRC covers exactly the bits transmitted, excluding SOC and parity.
- Frame length in bit periods: 1 + Σ(bits + parity_en) + (append_crc ? 16 + 2·parity_en : 0) + 1.

Test Plan:
- 1 byte 0xA5, parity_en=1, no CRC, defaults:
  - busy high exactly 11×128=1408 ticks.
  - Bit stream 1,1,0,1,0,0,1,0,1,1 (parity 1), then EOC.
  - One req at tick 0 of the parity bit; one done at the end.
- Bytes 0x00,0x00 with append_crc=1, parity_en=1:
  - CRC bytes sent 0xA0 then 0x1E.
  - Total 1+36+1=38 bit periods.
  - Exactly 2 req pulses.
- Bytes 0x12,0x34 with CRC, parity_en=0: CRC bytes 0x26, 0xCF; frame 34 bit periods; req on each last data bit.
- data_bits=7 short frame 0x26, parity_en=0, no CRC: 9 bit periods; tx waveform in SOC = 8-tick subcarrier bursts in the first 64 ticks only.
- fdt_trigger with ready_to_send=0, and fdt_trigger while busy: no state change and no extra req/done. Sweep BIT_TICKS=64, SC_HALF=4: timing scales accordingly.
- Assert rst_n=0 mid-DATA: next edge tx=0, busy=0, req=0, done=0; a new fdt_trigger afterwards starts a clean frame with CRC re-preset.
